// File: rtl/icache_refill_if.sv
// Bundle of the refill engine's IF-stage, icache-write and RAM-port signals.
// Names carry the engine's direction: _i is driven by the environment, _o by the engine.
interface icache_refill_if #(
  parameter int ADDR_W = 32
);
  logic              fetch_req_i;
  logic [ADDR_W-1:0] pc_i;
  logic              cache_hit_i;
  logic              flush_i;
  logic              mem_gnt_i;
  logic [7:0]        mem_din_i;
  logic              mem_req_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic              cache_we_o;
  logic [ADDR_W-1:0] cache_waddr_o;
  logic [31:0]       cache_wdata_o;
  logic              inst_valid_o;
  logic [31:0]       inst_o;
  logic [ADDR_W-1:0] inst_pc_o;
  logic              busy_o;

  modport master (
    input  fetch_req_i, pc_i, cache_hit_i, flush_i, mem_gnt_i, mem_din_i,
    output mem_req_o, mem_addr_o, cache_we_o, cache_waddr_o, cache_wdata_o,
           inst_valid_o, inst_o, inst_pc_o, busy_o
  );

  modport slave (
    output fetch_req_i, pc_i, cache_hit_i, flush_i, mem_gnt_i, mem_din_i,
    input  mem_req_o, mem_addr_o, cache_we_o, cache_waddr_o, cache_wdata_o,
           inst_valid_o, inst_o, inst_pc_o, busy_o
  );
endinterface

// File: rtl/icache_refill.sv
// Instruction-miss refill engine: fetches 4 bytes over an 8-bit RAM port, assembles
// a little-endian word, writes it into the icache and hands it to IF with its PC.
module icache_refill #(
  parameter int ADDR_W  = 32,
  parameter int MEM_LAT = 1
) (
  input logic             clk,
  input logic             rst,
  input logic             rdy,
  icache_refill_if.master bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic [2:0]          issueCnt_q, issueCnt_d;
  logic [2:0]          recvCnt_q, recvCnt_d;
  logic [31:0]         word_q, word_d;
  logic [MEM_LAT-1:0]  trkValid_q, trkValid_d;
  logic [1:0]          trkIdx_q [MEM_LAT];
  logic [1:0]          trkIdx_d [MEM_LAT];

  logic       issueWanted;
  logic       issue;
  logic       capture;
  logic [1:0] capIdx;
  logic       isDone;

  assign issueWanted = (state_q == FETCH) && (issueCnt_q != 3'd4);
  assign issue       = rdy && issueWanted && bus.mem_gnt_i;
  assign capture     = trkValid_q[MEM_LAT-1];
  assign capIdx      = trkIdx_q[MEM_LAT-1];
  assign isDone      = (state_q == DONE);

  // The tracker delays each issued byte index by exactly MEM_LAT enabled cycles,
  // so the byte on mem_din_i is always matched to the request that produced it.
  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    issueCnt_d = issueCnt_q;
    recvCnt_d  = recvCnt_q;
    word_d     = word_q;
    trkValid_d = trkValid_q;
    trkIdx_d   = trkIdx_q;
    if (rdy) begin
      case (state_q)
        IDLE: begin
          if (bus.fetch_req_i && !bus.cache_hit_i && !bus.flush_i) begin
            base_d     = bus.pc_i & ~{{(ADDR_W-2){1'b0}}, 2'b11};
            issueCnt_d = 3'd0;
            recvCnt_d  = 3'd0;
            word_d     = 32'd0;
            trkValid_d = '0;
            state_d    = FETCH;
          end
        end
        FETCH: begin
          if (bus.flush_i) begin
            issueCnt_d = 3'd0;
            recvCnt_d  = 3'd0;
            trkValid_d = '0;
            state_d    = IDLE;
          end else begin
            trkValid_d[0] = issue;
            trkIdx_d[0]   = issueCnt_q[1:0];
            for (int i = 1; i < MEM_LAT; i++) begin
              trkValid_d[i] = trkValid_q[i-1];
              trkIdx_d[i]   = trkIdx_q[i-1];
            end
            if (issue) issueCnt_d = issueCnt_q + 3'd1;
            if (capture) begin
              word_d[{capIdx, 3'b000} +: 8] = bus.mem_din_i;
              recvCnt_d = recvCnt_q + 3'd1;
              if (recvCnt_q == 3'd3) state_d = DONE;
            end
          end
        end
        DONE: begin
          issueCnt_d = 3'd0;
          recvCnt_d  = 3'd0;
          trkValid_d = '0;
          state_d    = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      base_q     <= '0;
      issueCnt_q <= 3'd0;
      recvCnt_q  <= 3'd0;
      word_q     <= 32'd0;
      trkValid_q <= '0;
      for (int i = 0; i < MEM_LAT; i++) trkIdx_q[i] <= 2'd0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      issueCnt_q <= issueCnt_d;
      recvCnt_q  <= recvCnt_d;
      word_q     <= word_d;
      trkValid_q <= trkValid_d;
      for (int i = 0; i < MEM_LAT; i++) trkIdx_q[i] <= trkIdx_d[i];
    end
  end

  // Outputs decode the registered state; the strobes are additionally gated by rdy,
  // and a flush arriving in DONE still lets the (correct) cache write through.
  assign bus.busy_o        = (state_q != IDLE);
  assign bus.mem_req_o     = issueWanted;
  assign bus.mem_addr_o    = issueWanted ? (base_q | {{(ADDR_W-2){1'b0}}, issueCnt_q[1:0]}) : '0;
  assign bus.cache_we_o    = isDone && rdy;
  assign bus.cache_waddr_o = isDone ? base_q : '0;
  assign bus.cache_wdata_o = isDone ? word_q : 32'd0;
  assign bus.inst_valid_o  = isDone && rdy && !bus.flush_i;
  assign bus.inst_o        = isDone ? word_q : 32'd0;
  assign bus.inst_pc_o     = isDone ? base_q : '0;

endmodule

// File: tb/tb_icache_refill.sv
// Directed bench for icache_refill: one instance with 1-cycle RAM latency and one with 2,
// both fed the same stimulus, each with its own small RAM model.
module tb_icache_refill;

  logic        clk;
  logic        rst;
  logic        rdy;
  logic        fetchReq;
  logic [31:0] pc;
  logic        hit;
  logic        flush;
  logic        gnt;
  logic [7:0]  din1;
  logic [7:0]  din2;
  logic [31:0] a2;
  logic        a2Valid;
  int          checkCount;
  int          errorCount;
  int          n1;
  int          n2;

  icache_refill_if #(.ADDR_W(32)) bus1 ();
  icache_refill_if #(.ADDR_W(32)) bus2 ();

  icache_refill #(.ADDR_W(32), .MEM_LAT(1)) dut1 (.clk(clk), .rst(rst), .rdy(rdy), .bus(bus1));
  icache_refill #(.ADDR_W(32), .MEM_LAT(2)) dut2 (.clk(clk), .rst(rst), .rdy(rdy), .bus(bus2));

  assign bus1.fetch_req_i = fetchReq;
  assign bus1.pc_i        = pc;
  assign bus1.cache_hit_i = hit;
  assign bus1.flush_i     = flush;
  assign bus1.mem_gnt_i   = gnt;
  assign bus1.mem_din_i   = din1;
  assign bus2.fetch_req_i = fetchReq;
  assign bus2.pc_i        = pc;
  assign bus2.cache_hit_i = hit;
  assign bus2.flush_i     = flush;
  assign bus2.mem_gnt_i   = gnt;
  assign bus2.mem_din_i   = din2;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] ramByte(input logic [31:0] a);
    case (a)
      32'h0000_0040: ramByte = 8'h93;
      32'h0000_0041: ramByte = 8'h00;
      32'h0000_0042: ramByte = 8'h10;
      32'h0000_0043: ramByte = 8'h00;
      32'h0000_1004: ramByte = 8'h13;
      32'h0000_1005: ramByte = 8'h05;
      32'h0000_1006: ramByte = 8'h10;
      32'h0000_1007: ramByte = 8'h00;
      32'h0000_2000: ramByte = 8'h11;
      32'h0000_2001: ramByte = 8'h22;
      32'h0000_2002: ramByte = 8'h33;
      32'h0000_2003: ramByte = 8'h44;
      default:       ramByte = 8'hEE;
    endcase
  endfunction

  // RAM with 1-cycle read latency; rdy=0 pauses it together with the DUT
  always @(posedge clk) begin
    if (rdy && bus1.mem_req_o && gnt) din1 <= ramByte(bus1.mem_addr_o);
  end

  // RAM with 2-cycle read latency
  always @(posedge clk) begin
    if (rdy) begin
      a2Valid <= bus2.mem_req_o && gnt;
      a2      <= bus2.mem_addr_o;
      if (a2Valid) din2 <= ramByte(a2);
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic req, input logic [31:0] p, input logic h,
                               input logic f, input logic g);
    fetchReq = req;
    pc       = p;
    hit      = h;
    flush    = f;
    gnt      = g;
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) tick();
  endtask

  task automatic waitWe(input int which, output int n);
    logic seen;
    n = 0;
    #1;
    seen = (which == 1) ? bus1.cache_we_o : bus2.cache_we_o;
    while (!seen && n < 30) begin
      tick();
      n++;
      seen = (which == 1) ? bus1.cache_we_o : bus2.cache_we_o;
    end
    if (!seen) checkOutput($sformatf("we_timeout_dut%0d", which), {31'd0, seen}, 32'd1);
  endtask

  initial begin
    checkCount = 0;
    errorCount = 0;
    rst  = 1'b0;
    rdy  = 1'b1;
    din1 = 8'h00;
    din2 = 8'h00;
    a2   = 32'd0;
    a2Valid = 1'b0;
    applyStimulus(0, 32'd0, 0, 0, 1);

    // reset state
    #3;
    checkOutput("rst_busy", {31'd0, bus1.busy_o}, 32'd0);
    checkOutput("rst_req", {31'd0, bus1.mem_req_o}, 32'd0);
    checkOutput("rst_we", {31'd0, bus1.cache_we_o}, 32'd0);
    checkOutput("rst_valid", {31'd0, bus1.inst_valid_o}, 32'd0);
    idle(2);
    rst = 1'b1;
    idle(2);

    $display("[TB] test 1: async reset mid-FETCH");
    applyStimulus(1, 32'h1004, 0, 0, 1);
    tick();
    applyStimulus(0, 32'd0, 0, 0, 1);
    tick();
    rst = 1'b0;
    #1;
    checkOutput("t1_busy1", {31'd0, bus1.busy_o}, 32'd0);
    checkOutput("t1_req1", {31'd0, bus1.mem_req_o}, 32'd0);
    checkOutput("t1_addr1", bus1.mem_addr_o, 32'd0);
    checkOutput("t1_busy2", {31'd0, bus2.busy_o}, 32'd0);
    tick();
    rst = 1'b1;
    idle(3);
    applyStimulus(1, 32'h40, 0, 0, 1);
    tick();
    applyStimulus(0, 32'd0, 0, 0, 1);
    waitWe(1, n1);
    checkOutput("t1_wdata1", bus1.cache_wdata_o, 32'h0010_0093);
    checkOutput("t1_pc1", bus1.inst_pc_o, 32'h40);
    checkOutput("t1_valid1", {31'd0, bus1.inst_valid_o}, 32'd1);
    waitWe(2, n2);
    checkOutput("t1_wdata2", bus2.cache_wdata_o, 32'h0010_0093);
    idle(4);

    $display("[TB] test 2: miss at 0x1006, continuous grant");
    applyStimulus(1, 32'h1006, 0, 0, 1);
    tick();
    applyStimulus(0, 32'd0, 0, 0, 1);
    #1;
    for (int c = 0; c < 4; c++) begin
      checkOutput($sformatf("t2_req_%0d", c), {31'd0, bus1.mem_req_o}, 32'd1);
      checkOutput($sformatf("t2_addr_%0d", c), bus1.mem_addr_o, 32'h1004 + c);
      tick();
    end
    checkOutput("t2_req_drop", {31'd0, bus1.mem_req_o}, 32'd0);
    checkOutput("t2_we_early", {31'd0, bus1.cache_we_o}, 32'd0);
    tick();
    checkOutput("t2_we", {31'd0, bus1.cache_we_o}, 32'd1);
    checkOutput("t2_wdata", bus1.cache_wdata_o, 32'h0010_0513);
    checkOutput("t2_waddr", bus1.cache_waddr_o, 32'h1004);
    checkOutput("t2_valid", {31'd0, bus1.inst_valid_o}, 32'd1);
    checkOutput("t2_inst", bus1.inst_o, 32'h0010_0513);
    checkOutput("t2_pc", bus1.inst_pc_o, 32'h1004);
    checkOutput("t2_we2_early", {31'd0, bus2.cache_we_o}, 32'd0);
    tick();
    checkOutput("t2_we_once", {31'd0, bus1.cache_we_o}, 32'd0);
    checkOutput("t2_busy_end", {31'd0, bus1.busy_o}, 32'd0);
    checkOutput("t2_we2", {31'd0, bus2.cache_we_o}, 32'd1);
    checkOutput("t2_wdata2", bus2.cache_wdata_o, 32'h0010_0513);
    idle(4);

    $display("[TB] test 3: hit keeps the engine idle");
    applyStimulus(1, 32'h1004, 1, 0, 1);
    for (int c = 0; c < 3; c++) begin
      tick();
      checkOutput("t3_req", {31'd0, bus1.mem_req_o}, 32'd0);
      checkOutput("t3_we", {31'd0, bus1.cache_we_o}, 32'd0);
      checkOutput("t3_valid", {31'd0, bus1.inst_valid_o}, 32'd0);
      checkOutput("t3_busy", {31'd0, bus1.busy_o}, 32'd0);
    end
    applyStimulus(0, 32'd0, 0, 0, 1);
    idle(2);

    $display("[TB] test 4: grant gaps at T+2, T+3");
    applyStimulus(1, 32'h1006, 0, 0, 1);
    tick();
    applyStimulus(0, 32'd0, 0, 0, 1);
    #1;
    checkOutput("t4_addr_t1", bus1.mem_addr_o, 32'h1004);
    tick();
    gnt = 1'b0;
    #1;
    checkOutput("t4_addr_t2", bus1.mem_addr_o, 32'h1005);
    tick();
    checkOutput("t4_addr_t3", bus1.mem_addr_o, 32'h1005);
    checkOutput("t4_req_t3", {31'd0, bus1.mem_req_o}, 32'd1);
    tick();
    gnt = 1'b1;
    #1;
    checkOutput("t4_addr_t4", bus1.mem_addr_o, 32'h1005);
    tick();
    checkOutput("t4_addr_t5", bus1.mem_addr_o, 32'h1006);
    tick();
    checkOutput("t4_addr_t6", bus1.mem_addr_o, 32'h1007);
    tick();
    checkOutput("t4_we_t7", {31'd0, bus1.cache_we_o}, 32'd0);
    tick();
    checkOutput("t4_we_t8", {31'd0, bus1.cache_we_o}, 32'd1);
    checkOutput("t4_wdata", bus1.cache_wdata_o, 32'h0010_0513);
    tick();
    checkOutput("t4_we2_t9", {31'd0, bus2.cache_we_o}, 32'd1);
    checkOutput("t4_wdata2", bus2.cache_wdata_o, 32'h0010_0513);
    idle(4);

    $display("[TB] test 5: flush in FETCH, then new miss at 0x2000");
    applyStimulus(1, 32'h1006, 0, 0, 1);
    tick();
    applyStimulus(0, 32'd0, 0, 0, 1);
    tick();
    tick();
    applyStimulus(0, 32'd0, 0, 1, 1);
    #1;
    checkOutput("t5_busy_at_flush", {31'd0, bus1.busy_o}, 32'd1);
    tick();
    applyStimulus(1, 32'h2000, 0, 0, 1);
    #1;
    checkOutput("t5_idle_after_flush", {31'd0, bus1.busy_o}, 32'd0);
    checkOutput("t5_req_after_flush", {31'd0, bus1.mem_req_o}, 32'd0);
    tick();
    applyStimulus(0, 32'd0, 0, 0, 1);
    waitWe(1, n1);
    checkOutput("t5_latency1", n1, 32'd5);
    checkOutput("t5_waddr1", bus1.cache_waddr_o, 32'h2000);
    checkOutput("t5_wdata1", bus1.cache_wdata_o, 32'h4433_2211);
    waitWe(2, n2);
    checkOutput("t5_waddr2", bus2.cache_waddr_o, 32'h2000);
    checkOutput("t5_wdata2", bus2.cache_wdata_o, 32'h4433_2211);
    idle(4);

    $display("[TB] test 5b: flush in DONE");
    applyStimulus(1, 32'h1004, 0, 0, 1);
    tick();
    applyStimulus(0, 32'd0, 0, 0, 1);
    waitWe(1, n1);
    applyStimulus(0, 32'd0, 0, 1, 1);
    #1;
    checkOutput("t5b_we", {31'd0, bus1.cache_we_o}, 32'd1);
    checkOutput("t5b_valid", {31'd0, bus1.inst_valid_o}, 32'd0);
    checkOutput("t5b_wdata", bus1.cache_wdata_o, 32'h0010_0513);
    tick();
    applyStimulus(0, 32'd0, 0, 0, 1);
    #1;
    checkOutput("t5b_idle", {31'd0, bus1.busy_o}, 32'd0);
    idle(4);

    $display("[TB] test 6: rdy low for 3 cycles during FETCH");
    applyStimulus(1, 32'h1004, 0, 0, 1);
    tick();
    applyStimulus(0, 32'd0, 0, 0, 1);
    tick();
    rdy = 1'b0;
    #1;
    for (int c = 0; c < 3; c++) begin
      checkOutput($sformatf("t6_req2_%0d", c), {31'd0, bus2.mem_req_o}, 32'd1);
      checkOutput($sformatf("t6_addr2_%0d", c), bus2.mem_addr_o, 32'h1005);
      checkOutput($sformatf("t6_we2_%0d", c), {31'd0, bus2.cache_we_o}, 32'd0);
      tick();
    end
    rdy = 1'b1;
    waitWe(1, n1);
    checkOutput("t6_latency1", n1, 32'd4);
    checkOutput("t6_wdata1", bus1.cache_wdata_o, 32'h0010_0513);
    waitWe(2, n2);
    checkOutput("t6_latency2", n1 + n2, 32'd5);
    checkOutput("t6_wdata2", bus2.cache_wdata_o, 32'h0010_0513);
    checkOutput("t6_pc2", bus2.inst_pc_o, 32'h1004);
    idle(4);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checkCount, errorCount);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
